// File: rtl/banked_sync_ram.sv
// rtl/banked_sync_ram.sv - banked single-port word RAM with lane write enables, clear engine and 1/2-cycle read latency
module banked_sync_ram #(
  parameter int ADDR_WIDTH   = 15,
  parameter int DATA_WIDTH   = 16,
  parameter int LANE_WIDTH   = 8,
  parameter int BANK_BITS    = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clr_req,
  output logic                                 clr_busy,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_we,
  input  logic [ADDR_WIDTH-1:0]                req_addr,
  input  logic [DATA_WIDTH-1:0]                req_wdata,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0]     req_be,
  output logic                                 rsp_valid,
  output logic [DATA_WIDTH-1:0]                rsp_rdata
);

  localparam int LANES    = DATA_WIDTH / LANE_WIDTH;
  localparam int ROW_BITS = ADDR_WIDTH - BANK_BITS;
  localparam int BANKS    = 2 ** BANK_BITS;
  localparam int ROWS     = 2 ** ROW_BITS;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                state;
  logic [ROW_BITS-1:0]   clr_cnt;
  logic [BANK_BITS-1:0]  bank_sel;
  logic [ROW_BITS-1:0]   row_sel;
  logic                  req_fire;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  clr_active;
  logic [DATA_WIDTH-1:0] bank_rdata [BANKS];
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  assign bank_sel   = req_addr[ADDR_WIDTH-1 -: BANK_BITS];
  assign row_sel    = req_addr[ROW_BITS-1:0];
  // A clear request in the same cycle blocks the request so nothing slips in ahead of the wipe.
  assign req_ready  = (state == IDLE) & ~clr_req;
  // Reset suppresses any array update on the edge it is sampled.
  assign req_fire   = req_valid & req_ready & ~rst;
  assign wr_fire    = req_fire & req_we;
  assign rd_fire    = req_fire & ~req_we;
  assign clr_active = (state == CLEAR) & ~rst;

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    localparam logic [BANK_BITS-1:0] BANK_ID = BANK_BITS'(b);
    logic [DATA_WIDTH-1:0] mem [ROWS];

    // Bank array: clear sweep writes the counter row, otherwise a selected write updates enabled lanes.
    always_ff @(posedge clk) begin
      if (clr_active) begin
        mem[clr_cnt] <= '0;
      end else if (wr_fire && (bank_sel == BANK_ID)) begin
        for (int i = 0; i < LANES; i++) begin
          if (req_be[i]) begin
            mem[row_sel][i*LANE_WIDTH +: LANE_WIDTH] <= req_wdata[i*LANE_WIDTH +: LANE_WIDTH];
          end
        end
      end
    end

    assign bank_rdata[b] = mem[row_sel];
  end

  // Clear engine FSM: sweeps all rows once, then idles until a clear request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= CLEAR;
      clr_busy <= 1'b1;
      clr_cnt  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == {ROW_BITS{1'b1}}) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
          end
        end
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            clr_busy <= 1'b1;
          end
        end
        default: begin
          state    <= CLEAR;
          clr_busy <= 1'b1;
        end
      endcase
    end
  end

  // First read stage: capture the addressed word on the accept edge; data holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_fire;
      if (rd_fire) begin
        s1_data <= bank_rdata[bank_sel];
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  s2_valid;
    logic [DATA_WIDTH-1:0] s2_data;

    // Optional output register stage; keeps draining while the clear engine runs.
    always_ff @(posedge clk) begin
      if (rst) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data <= s1_data;
        end
      end
    end

    assign rsp_valid = s2_valid;
    assign rsp_rdata = s2_data;
  end else begin : g_lat1
    assign rsp_valid = s1_valid;
    assign rsp_rdata = s1_data;
  end

endmodule

// File: tb/tb_banked_sync_ram.sv
// tb/tb_banked_sync_ram.sv - scoreboard bench running latency-1 and latency-2 instances side by side
module tb_banked_sync_ram;
  localparam int AW = 6;
  localparam int DW = 16;
  localparam int LN = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          clr_req;
  logic          req_valid;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [LN-1:0] req_be;
  logic          busy1, ready1, rv1;
  logic          busy2, ready2, rv2;
  logic [DW-1:0] rd1, rd2;

  banked_sync_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(8), .BANK_BITS(2), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(busy1),
    .req_valid(req_valid), .req_ready(ready1), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv1), .rsp_rdata(rd1)
  );

  banked_sync_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(8), .BANK_BITS(2), .READ_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .clr_busy(busy2),
    .req_valid(req_valid), .req_ready(ready2), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv2), .rsp_rdata(rd2)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          q1[$];
  exp_t          q2[$];
  exp_t          e1, e2;
  logic [DW-1:0] model [64];
  int            total = 0;
  int            bad = 0;
  int            nc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) model[i] = '0;
  endtask

  // response monitor: count negedges, pop and compare on every rsp_valid
  always @(negedge clk) begin
    nc++;
    if (rv1) begin
      if (q1.size() == 0) check("lat1_extra_rsp", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        check("lat1_data", 32'(rd1), 32'(e1.data));
        check("lat1_cycle", 32'(nc), 32'(e1.due));
      end
    end
    if (rv2) begin
      if (q2.size() == 0) check("lat2_extra_rsp", 32'd1, 32'd0);
      else begin
        e2 = q2.pop_front();
        check("lat2_data", 32'(rd2), 32'(e2.data));
        check("lat2_cycle", 32'(nc), 32'(e2.due));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      clr_req   = 1'b0;
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [LN-1:0] be);
    @(posedge clk); #1;
    clr_req = 1'b0; req_valid = 1'b1; req_we = 1'b1;
    req_addr = a; req_wdata = d; req_be = be;
    #1;
    check("wr_ready", {30'd0, ready1, ready2}, 32'd3);
    if (be[0]) model[a][7:0]  = d[7:0];
    if (be[1]) model[a][15:8] = d[15:8];
  endtask

  task automatic rd(input logic [AW-1:0] a, input bit push2);
    exp_t e;
    @(posedge clk); #1;
    clr_req = 1'b0; req_valid = 1'b1; req_we = 1'b0;
    req_addr = a; req_wdata = '0; req_be = '0;
    e.data = model[a];
    e.due  = nc + 2;
    q1.push_back(e);
    if (push2) begin
      e.due = nc + 3;
      q2.push_back(e);
    end
    #1;
    check("rd_ready", {30'd0, ready1, ready2}, 32'd3);
  endtask

  // count negedges with clr_busy high, starting at the first negedge after the call
  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(tag, 32'(n), 32'd16);
    check({tag, "_lat2"}, {30'd0, busy2, ready2}, 32'd1);
    check({tag, "_ready"}, {31'd0, ready1}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; clr_req = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state1", {28'd0, busy1, ready1, rv1, 1'b0}, 32'h8);
    check("rst_state2", {28'd0, busy2, ready2, rv2, 1'b0}, 32'h8);
    check("rst_rdata", {rd1, rd2}, 32'd0);

    // 1: clear length after reset release, then every word reads zero
    @(posedge clk); #1; rst = 1'b0;
    wait_busy("t1_busy");
    for (int a = 0; a < 64; a++) rd(AW'(a), 1'b1);
    idle(4);

    // 2: full write, read back, neighbour bank untouched
    wr(6'h05, 16'hA5C3, 2'b11);
    rd(6'h05, 1'b1);
    rd(6'h15, 1'b1);
    idle(4);

    // 3: lane masking, including an all-off mask
    wr(6'h3F, 16'hFFFF, 2'b11);
    wr(6'h3F, 16'h1200, 2'b10);
    rd(6'h3F, 1'b1);
    wr(6'h3F, 16'h0000, 2'b00);
    rd(6'h3F, 1'b1);
    idle(4);

    // 4: back-to-back reads across all banks
    wr(6'h00, 16'h1111, 2'b11);
    wr(6'h10, 16'h2222, 2'b11);
    wr(6'h20, 16'h3333, 2'b11);
    wr(6'h30, 16'h4444, 2'b11);
    rd(6'h00, 1'b1);
    rd(6'h10, 1'b1);
    rd(6'h20, 1'b1);
    rd(6'h30, 1'b1);
    idle(4);

    // 5: clear request beats a same-cycle write
    @(posedge clk); #1;
    clr_req = 1'b1; req_valid = 1'b1; req_we = 1'b1;
    req_addr = 6'h07; req_wdata = 16'hBEEF; req_be = 2'b11;
    #1;
    check("t5_ready", {30'd0, ready1, ready2}, 32'd0);
    @(posedge clk); #1;
    clr_req = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    wait_busy("t5_busy");
    model_clear();
    rd(6'h07, 1'b1);
    rd(6'h05, 1'b1);
    idle(4);

    // 6a: read issued while reset is asserted is dropped on both latencies; rdata clears
    wr(6'h21, 16'h5A5A, 2'b11);
    rd(6'h21, 1'b1);
    idle(4);
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 6'h21;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("t6a_rdata", {rd1, rd2}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    wait_busy("t6a_busy");
    model_clear();

    // 6b: reset one cycle after a read accept kills only the latency-2 response
    wr(6'h22, 16'h7777, 2'b11);
    rd(6'h22, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1; rst = 1'b0;
    wait_busy("t6b_busy");
    model_clear();

    // 6c: reset at clear cycle 8 restarts a full sweep
    wr(6'h30, 16'h9999, 2'b11);
    @(posedge clk); #1;
    req_valid = 1'b0; clr_req = 1'b1;
    @(posedge clk); #1;
    clr_req = 1'b0;
    repeat (7) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    wait_busy("t6c_busy");
    model_clear();
    rd(6'h30, 1'b1);
    rd(6'h22, 1'b1);
    idle(5);

    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q2_drained", 32'(q2.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
